// File: rtl/debug_types_1_12_pkg.sv
// debug_types_1_12_pkg: shared types and addresses for the priv 1.12 debug extension
package debug_types_1_12_pkg;
  localparam logic [11:0] DCSR_ADDR      = 12'h7B0;
  localparam logic [11:0] DPC_ADDR       = 12'h7B1;
  localparam logic [11:0] DSCRATCH0_ADDR = 12'h7B2;
  localparam logic [11:0] DSCRATCH1_ADDR = 12'h7B3;
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    EBREAK  = 3'd1,
    HALTREQ = 3'd3,
    STEP    = 3'd4
  } debug_cause_t;
  typedef enum logic [1:0] {
    RUNNING,
    HALTED,
    RESUMING
  } debug_state_t;
  typedef struct packed {
    logic [3:0]   xdebugver;
    logic [11:0]  rsvd_27_16;
    logic         ebreakm;
    logic [1:0]   rsvd_14_13;
    logic         ebreaku;
    logic         stepie;
    logic         stopcount;
    logic         stoptime;
    debug_cause_t cause;
    logic         rsvd_5;
    logic         mprven;
    logic         nmip;
    logic         step;
    logic [1:0]   prv;
  } dcsr_t;
  function automatic logic [1:0] legal_prv(input logic [1:0] p);
    return (p == 2'b10 || p == 2'b01) ? 2'b00 : p;
  endfunction
endpackage

// File: rtl/priv_1_12_debug.sv
// priv_1_12_debug: debug CSR responder and halt/resume/single-step control
import debug_types_1_12_pkg::*;
module priv_1_12_debug #(
  parameter int HARTID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [11:0] csr_addr,
  input  logic [31:0] value_in,
  input  logic        csr_active,
  output logic        ack,
  output logic [31:0] value_out,
  output logic        invalid_csr,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        ebreak_hit,
  input  logic [31:0] ebreak_pc,
  input  logic [31:0] next_pc,
  input  logic        inst_ret,
  input  logic [1:0]  curr_priv,
  output logic        debug_mode,
  output logic        resume_valid,
  output logic [31:0] resume_pc,
  output logic [1:0]  resume_priv
);
  if (HARTID < 0) begin : g_bad_hartid
  end
  debug_state_t state, next_state;
  debug_cause_t cause, entry_cause;
  logic ebreakm, ebreaku, stepie, step, step_armed;
  logic [1:0] prv;
  logic [31:0] dpc, dscratch0, dscratch1, entry_pc;
  logic in_range, wr, ebreak_go, enter;
  dcsr_t dcsr;
  always_comb begin
    dcsr = '0;
    dcsr.xdebugver = 4'd4;
    dcsr.ebreakm = ebreakm;
    dcsr.ebreaku = ebreaku;
    dcsr.stepie = stepie;
    dcsr.cause = cause;
    dcsr.step = step;
    dcsr.prv = prv;
  end
  assign in_range = csr_addr[11:2] == DCSR_ADDR[11:2];
  assign debug_mode = state != RUNNING;
  assign ack = in_range && debug_mode;
  assign invalid_csr = in_range && !debug_mode;
  assign wr = ack && csr_active;
  assign value_out = csr_addr == DCSR_ADDR      ? dcsr :
                     csr_addr == DPC_ADDR       ? dpc :
                     csr_addr == DSCRATCH0_ADDR ? dscratch0 :
                     csr_addr == DSCRATCH1_ADDR ? dscratch1 : 32'h0;
  assign resume_valid = state == RESUMING;
  assign resume_pc = dpc;
  assign resume_priv = prv;
  // curr_priv 01/10 never matches an ebreak enable
  assign ebreak_go = ebreak_hit && ((curr_priv == 2'b11 && ebreakm) || (curr_priv == 2'b00 && ebreaku));
  assign enter = ebreak_go || halt_req || (step_armed && inst_ret);
  assign entry_cause = ebreak_go ? EBREAK : halt_req ? HALTREQ : STEP;
  assign entry_pc = ebreak_go ? ebreak_pc : next_pc;
  always_comb begin
    next_state = state;
    if (state == RUNNING)
      next_state = enter ? HALTED : RUNNING;
    else if (state == HALTED)
      next_state = resume_req ? RESUMING : HALTED;
    else
      next_state = RUNNING;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= RUNNING;
    else state <= next_state;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      cause <= NONE;
      prv <= 2'b11;
      {ebreakm, ebreaku, stepie, step, step_armed} <= '0;
      dpc <= '0;
      dscratch0 <= '0;
      dscratch1 <= '0;
    end else begin
      if (state == RUNNING && enter) begin
        cause <= entry_cause;
        dpc <= entry_pc;
        prv <= curr_priv;
        step_armed <= 1'b0;
      end
      if (state == RESUMING) step_armed <= step;
      if (wr && csr_addr == DCSR_ADDR) begin
        ebreakm <= value_in[15];
        ebreaku <= value_in[12];
        stepie <= value_in[11];
        step <= value_in[2];
        prv <= legal_prv(value_in[1:0]);
      end
      if (wr && csr_addr == DPC_ADDR) dpc <= {value_in[31:1], 1'b0};
      if (wr && csr_addr == DSCRATCH0_ADDR) dscratch0 <= value_in;
      if (wr && csr_addr == DSCRATCH1_ADDR) dscratch1 <= value_in;
    end
endmodule

// File: tb/tb_priv_1_12_debug.sv
// tb_priv_1_12_debug: directed-vector bench for priv_1_12_debug
module tb_priv_1_12_debug;
  logic CLK = 0, nRST = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] value_in = 0, ebreak_pc = 0, next_pc = 0;
  logic csr_active = 0, halt_req = 0, resume_req = 0, ebreak_hit = 0, inst_ret = 0;
  logic [1:0] curr_priv = 2'b11;
  logic ack, invalid_csr, debug_mode, resume_valid;
  logic [31:0] value_out, resume_pc;
  logic [1:0] resume_priv;
  int pass_cnt = 0, total_cnt = 0;
  priv_1_12_debug #(.HARTID(0)) dut (
    .CLK(CLK), .nRST(nRST), .csr_addr(csr_addr), .value_in(value_in), .csr_active(csr_active),
    .ack(ack), .value_out(value_out), .invalid_csr(invalid_csr), .halt_req(halt_req),
    .resume_req(resume_req), .ebreak_hit(ebreak_hit), .ebreak_pc(ebreak_pc), .next_pc(next_pc),
    .inst_ret(inst_ret), .curr_priv(curr_priv), .debug_mode(debug_mode), .resume_valid(resume_valid),
    .resume_pc(resume_pc), .resume_priv(resume_priv)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    {csr_active, halt_req, resume_req, ebreak_hit, inst_ret} = '0;
  endtask
  task automatic read(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, value_out, exp);
  endtask
  task automatic write(input logic [11:0] a, input logic [31:0] v);
    csr_addr = a;
    value_in = v;
    csr_active = 1;
    tick();
    csr_active = 0;
  endtask
  initial begin
    tick();
    tick();
    check("rst debug_mode", 32'(debug_mode), 0);
    check("rst resume_valid", 32'(resume_valid), 0);
    check("rst resume_pc", resume_pc, 0);
    check("rst resume_priv", 32'(resume_priv), 3);
    check("rst ack", 32'(ack), 0);
    check("rst invalid", 32'(invalid_csr), 0);
    nRST = 1;
    tick();
    csr_addr = 12'h7B0;
    #1;
    check("run ack", 32'(ack), 0);
    check("run invalid", 32'(invalid_csr), 1);
    csr_addr = 12'h123;
    #1;
    check("other invalid", 32'(invalid_csr), 0);
    check("other value", value_out, 0);
    write(12'h7B2, 32'h1234_5678);
    halt_req = 1;
    next_pc = 32'h8000_0100;
    tick();
    idle();
    check("halt debug_mode", 32'(debug_mode), 1);
    read("halt dcsr", 12'h7B0, 32'h4000_00C3);
    check("halt ack", 32'(ack), 1);
    check("halt invalid", 32'(invalid_csr), 0);
    read("halt dpc", 12'h7B1, 32'h8000_0100);
    read("ignored dscratch0", 12'h7B2, 0);
    write(12'h7B1, 32'h8000_0203);
    read("dpc bit0", 12'h7B1, 32'h8000_0202);
    write(12'h7B0, 32'h0000_0002);
    read("dcsr prv legal", 12'h7B0, 32'h4000_00C0);
    write(12'h7B3, 32'hDEAD_BEEF);
    read("dscratch1", 12'h7B3, 32'hDEAD_BEEF);
    resume_req = 1;
    tick();
    idle();
    check("resume valid", 32'(resume_valid), 1);
    check("resume pc", resume_pc, 32'h8000_0202);
    check("resume priv", 32'(resume_priv), 0);
    tick();
    check("resume pulse end", 32'(resume_valid), 0);
    check("running", 32'(debug_mode), 0);
    resume_req = 1;
    tick();
    idle();
    check("stray resume", 32'(resume_valid), 0);
    curr_priv = 2'b11;
    ebreak_hit = 1;
    ebreak_pc = 32'h44;
    inst_ret = 1;
    tick();
    idle();
    check("ebreak disabled", 32'(debug_mode), 0);
    halt_req = 1;
    next_pc = 32'h10;
    tick();
    idle();
    csr_addr = 12'h7B0;
    value_in = 32'h0000_8003;
    csr_active = 1;
    resume_req = 1;
    tick();
    idle();
    check("wr+resume priv", 32'(resume_priv), 3);
    check("wr+resume pc", resume_pc, 32'h10);
    tick();
    ebreak_hit = 1;
    ebreak_pc = 32'h44;
    tick();
    idle();
    check("ebreak halt", 32'(debug_mode), 1);
    read("ebreak dcsr", 12'h7B0, 32'h4000_8043);
    read("ebreak dpc", 12'h7B1, 32'h44);
    write(12'h7B0, 32'h0000_8007);
    resume_req = 1;
    tick();
    idle();
    tick();
    inst_ret = 1;
    next_pc = 32'h48;
    tick();
    idle();
    check("step halt", 32'(debug_mode), 1);
    read("step dcsr", 12'h7B0, 32'h4000_8107);
    read("step dpc", 12'h7B1, 32'h48);
    resume_req = 1;
    tick();
    idle();
    tick();
    ebreak_hit = 1;
    ebreak_pc = 32'h50;
    halt_req = 1;
    inst_ret = 1;
    next_pc = 32'h54;
    tick();
    idle();
    read("prio ebreak dcsr", 12'h7B0, 32'h4000_8047);
    read("prio ebreak dpc", 12'h7B1, 32'h50);
    resume_req = 1;
    tick();
    idle();
    tick();
    halt_req = 1;
    inst_ret = 1;
    next_pc = 32'h58;
    tick();
    idle();
    read("prio halt dcsr", 12'h7B0, 32'h4000_80C7);
    read("prio halt dpc", 12'h7B1, 32'h58);
    resume_req = 1;
    tick();
    idle();
    check("pre-reset resuming", 32'(resume_valid), 1);
    nRST = 0;
    #1;
    check("async rst valid", 32'(resume_valid), 0);
    check("async rst debug", 32'(debug_mode), 0);
    read("async rst dcsr", 12'h7B0, 32'h4000_0003);
    tick();
    nRST = 1;
    tick();
    check("post-reset running", 32'(debug_mode), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
